// File: rtl/xctcmsg_match_mbox.sv
// Tag-matching receive mailbox: arrival-ordered compacting message store, searched
// by (source, tag) with per-field wildcards; the oldest match is handed to writeback.
module xctcmsg_match_mbox #(
  parameter int DEPTH  = 8,
  parameter int SRC_W  = 32,
  parameter int TAG_W  = 32,
  parameter int DATA_W = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              bus_rdy_o,
  input  logic              bus_val_i,
  input  logic [SRC_W-1:0]  bus_src_i,
  input  logic [TAG_W-1:0]  bus_tag_i,
  input  logic [DATA_W-1:0] bus_msg_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [SRC_W-1:0]  req_src_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic              req_src_any_i,
  input  logic              req_tag_any_i,
  input  logic [4:0]        req_rd_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_register_o,
  output logic [DATA_W-1:0] wb_value_o,
  output logic [SRC_W-1:0]  wb_src_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEARCH, RESPOND} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [SRC_W-1:0]   src_reg  [DEPTH];
  logic [TAG_W-1:0]   tag_reg  [DEPTH];
  logic [DATA_W-1:0]  msg_reg  [DEPTH];
  logic [SRC_W-1:0]   src_next [DEPTH];
  logic [TAG_W-1:0]   tag_next [DEPTH];
  logic [DATA_W-1:0]  msg_next [DEPTH];

  logic [SRC_W-1:0]   rq_src_reg;
  logic [TAG_W-1:0]   rq_tag_reg;
  logic               rq_src_any_reg, rq_tag_any_reg;
  logic [4:0]         rq_rd_reg;

  logic               wb_valid_reg;
  logic [4:0]         wb_register_reg;
  logic [DATA_W-1:0]  wb_value_reg;
  logic [SRC_W-1:0]   wb_src_reg;
  logic [TAG_W-1:0]   wb_tag_reg;

  logic [DEPTH-1:0]   match;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               accept, remove;
  logic [CNT_W-1:0]   ins_idx;

  assign bus_rdy_o   = (count_reg < CNT_W'(DEPTH));
  assign req_ready_o = (state_reg == IDLE);
  assign accept      = bus_val_i && bus_rdy_o;

  // Only the registered store is searched; same-cycle arrivals wait a cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = (CNT_W'(gi) < count_reg)
                    && (rq_src_any_reg || src_reg[gi] == rq_src_reg)
                    && (rq_tag_any_reg || tag_reg[gi] == rq_tag_reg);
  end

  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    remove     = 1'b0;
    case (state_reg)
      IDLE:    if (req_valid_i) state_next = SEARCH;
      SEARCH:  if (hit) begin
                 state_next = RESPOND;
                 remove     = 1'b1;
               end
      RESPOND: if (wb_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      remove     = 1'b0;
    end
  end

  // Removal compacts entries above the winner; insert goes after the (shifted) tail.
  always_comb begin
    ins_idx    = remove ? count_reg - CNT_W'(1) : count_reg;
    count_next = count_reg + CNT_W'(accept) - CNT_W'(remove);
    for (int i = 0; i < DEPTH; i++) begin
      int j;
      j = (i < DEPTH - 1) ? i + 1 : i;
      src_next[i] = src_reg[i];
      tag_next[i] = tag_reg[i];
      msg_next[i] = msg_reg[i];
      if (remove && i >= int'(hit_idx)) begin
        src_next[i] = src_reg[j];
        tag_next[i] = tag_reg[j];
        msg_next[i] = msg_reg[j];
      end
      if (accept && i == int'(ins_idx)) begin
        src_next[i] = bus_src_i;
        tag_next[i] = bus_tag_i;
        msg_next[i] = bus_msg_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src_reg[i] <= '0;
        tag_reg[i] <= '0;
        msg_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      src_reg   <= src_next;
      tag_reg   <= tag_next;
      msg_reg   <= msg_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_src_reg      <= '0;
      rq_tag_reg      <= '0;
      rq_src_any_reg  <= 1'b0;
      rq_tag_any_reg  <= 1'b0;
      rq_rd_reg       <= '0;
      wb_valid_reg    <= 1'b0;
      wb_register_reg <= '0;
      wb_value_reg    <= '0;
      wb_src_reg      <= '0;
      wb_tag_reg      <= '0;
    end else begin
      if (state_reg == IDLE && req_valid_i && !flush) begin
        rq_src_reg     <= req_src_i;
        rq_tag_reg     <= req_tag_i;
        rq_src_any_reg <= req_src_any_i;
        rq_tag_any_reg <= req_tag_any_i;
        rq_rd_reg      <= req_rd_i;
      end
      wb_valid_reg <= (state_next == RESPOND);
      if (remove) begin
        wb_register_reg <= rq_rd_reg;
        wb_value_reg    <= msg_reg[hit_idx];
        wb_src_reg      <= src_reg[hit_idx];
        wb_tag_reg      <= tag_reg[hit_idx];
      end
    end
  end

  assign wb_valid_o    = wb_valid_reg;
  assign wb_register_o = wb_register_reg;
  assign wb_value_o    = wb_value_reg;
  assign wb_src_o      = wb_src_reg;
  assign wb_tag_o      = wb_tag_reg;
  assign count_o       = count_reg;

endmodule
